// File: rtl/memory.sv
// Memory-access pipeline stage: one outstanding data-bus request per load/store,
// stalling upstream until the response returns, zero-latency pass-through otherwise.
package pipes;
   typedef logic [63:0] word_t;
   typedef logic [63:0] addr_t;
   typedef logic [7:0]  strobe_t;

   typedef enum logic [1:0] {
      MSIZE1 = 2'd0,
      MSIZE2 = 2'd1,
      MSIZE4 = 2'd2,
      MSIZE8 = 2'd3
   } msize_t;

   typedef struct packed {
      logic   memread;
      logic   memwrite;
      msize_t msize;
      logic   memext;
   } control_t;

   typedef struct packed {
      logic        valid;
      addr_t       pc;
      logic [31:0] raw_instr;
      logic [4:0]  dst;
      control_t    ctl;
      word_t       aluout;
      word_t       memwd;
   } execute_data_t;

   typedef struct packed {
      logic        valid;
      addr_t       pc;
      logic [31:0] raw_instr;
      logic [4:0]  dst;
      control_t    ctl;
      word_t       result;
      logic        misalign;
   } memory_data_t;

   typedef struct packed {
      logic    valid;
      addr_t   addr;
      msize_t  size;
      strobe_t strobe;
      word_t   data;
   } dbus_req_t;

   typedef struct packed {
      logic  data_ok;
      word_t data;
   } dbus_resp_t;
endpackage

module memory
   import pipes::*;
(
   input  logic          clk,
   input  logic          reset,
   input  execute_data_t dataE,
   output memory_data_t  dataM,
   output dbus_req_t     dreq,
   input  dbus_resp_t    dresp,
   output logic          stallM
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state_r;
   state_t next_s;
   word_t  rdata_r;
   logic   capture_s;
   logic   memop_s;
   logic   misalign_s;
   logic   req_s;

   function automatic strobe_t base_mask(input msize_t size);
      case (size)
         MSIZE1:  base_mask = 8'h01;
         MSIZE2:  base_mask = 8'h03;
         MSIZE4:  base_mask = 8'h0F;
         MSIZE8:  base_mask = 8'hFF;
         default: base_mask = 8'h00;
      endcase
   endfunction

   function automatic logic is_misaligned(input msize_t size, input logic [2:0] off);
      case (size)
         MSIZE1:  is_misaligned = 1'b0;
         MSIZE2:  is_misaligned = off[0];
         MSIZE4:  is_misaligned = (off[1:0] != 2'd0);
         MSIZE8:  is_misaligned = (off != 3'd0);
         default: is_misaligned = 1'b1;
      endcase
   endfunction

   function automatic word_t extract(input word_t raw, input logic [2:0] off,
                                     input msize_t size, input logic zext);
      word_t sh;
      sh = raw >> {off, 3'b000};
      case (size)
         MSIZE1:  extract = zext ? {56'd0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
         MSIZE2:  extract = zext ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
         MSIZE4:  extract = zext ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
         MSIZE8:  extract = raw;
         default: extract = raw;
      endcase
   endfunction

   assign memop_s    = dataE.valid & (dataE.ctl.memread | dataE.ctl.memwrite);
   assign misalign_s = is_misaligned(dataE.ctl.msize, dataE.aluout[2:0]);

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_s;
      end
   end

   // Response capture register; only written when a request completes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata_r <= 64'd0;
      end else if (capture_s) begin
         rdata_r <= dresp.data;
      end else begin
         rdata_r <= rdata_r;
      end
   end

   // Next-state, request and stage-output logic.
   always_comb begin
      next_s          = state_r;
      capture_s       = 1'b0;
      req_s           = 1'b0;
      dataM.valid     = dataE.valid;
      dataM.pc        = dataE.pc;
      dataM.raw_instr = dataE.raw_instr;
      dataM.dst       = dataE.dst;
      dataM.ctl       = dataE.ctl;
      dataM.result    = dataE.aluout;
      dataM.misalign  = 1'b0;
      case (state_r)
         IDLE: begin
            if (memop_s && misalign_s) begin
               dataM.misalign = 1'b1;
            end else if (memop_s) begin
               req_s       = 1'b1;
               dataM.valid = 1'b0;
               if (dresp.data_ok) begin
                  capture_s = 1'b1;
                  next_s    = DONE;
               end else begin
                  next_s = WAIT;
               end
            end else begin
               next_s = IDLE;
            end
         end
         WAIT: begin
            req_s       = 1'b1;
            dataM.valid = 1'b0;
            if (dresp.data_ok) begin
               capture_s = 1'b1;
               next_s    = DONE;
            end else begin
               next_s = WAIT;
            end
         end
         DONE: begin
            dataM.valid = 1'b1;
            if (dataE.ctl.memread) begin
               dataM.result = extract(rdata_r, dataE.aluout[2:0],
                                      dataE.ctl.msize, dataE.ctl.memext);
            end else begin
               dataM.result = dataE.aluout;
            end
            next_s = IDLE;
         end
         default: begin
            next_s = IDLE;
         end
      endcase
      // Reset forces the request and stall low at once, abandoning any in-flight access.
      if (reset) begin
         req_s       = 1'b0;
         dataM.valid = 1'b0;
      end else begin
         req_s = req_s;
      end
   end

   assign stallM      = req_s;
   assign dreq.valid  = req_s;
   assign dreq.addr   = dataE.aluout;
   assign dreq.size   = dataE.ctl.msize;
   assign dreq.strobe = dataE.ctl.memwrite ? (base_mask(dataE.ctl.msize) << dataE.aluout[2:0])
                                           : 8'h00;
   assign dreq.data   = dataE.memwd << {dataE.aluout[2:0], 3'b000};

endmodule

// File: doc/memory.md
# memory

Pipeline memory-access stage, directly downstream of the execute stage. Consumes `execute_data_t` (ALU result as address, store data, control) and produces `memory_data_t` for writeback. Issues a single outstanding data-bus request per load/store and holds `stallM` high until the request completes. Non-memory instructions pass through with zero added latency.

## Interface
Parameters:
- none. Widths come from `common`/`pipes`: `word_t` = 64 bit, `addr_t` = 64 bit, `strobe_t` = 8 bit.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-high.
- `dataE` in `execute_data_t`: execute result. Uses `valid`, `pc`, `raw_instr`, `dst`, `ctl`, `aluout` (address), `memwd` (store data).
- `dataM` out `memory_data_t`: `valid`, `pc`, `raw_instr`, `dst`, `ctl`, `result` (load data or `aluout`), `misalign`.
- `dreq` out `dbus_req_t`: `valid`, `addr`, `size` (`msize_t`), `strobe`, `data`.
- `dresp` in `dbus_resp_t`: `data_ok`, `data`.
- `stallM` out 1: freezes EX/MEM and all upstream pipeline registers while high.

Control fields used:
- `ctl.memread`, `ctl.memwrite`: at most one of the two is set.
- `ctl.msize`: MSIZE1/2/4/8.
- `ctl.memext`: 1 = zero-extend load, 0 = sign-extend load.

## Operation
- FSM states: IDLE, WAIT, DONE. Reset enters IDLE.
- `memop = dataE.valid & (memread | memwrite)`.
- `misalign = addr[2:0]` not a multiple of the size in bytes.

IDLE:
- Non-memop: `dataM` passes through combinationally, `result = aluout`, `stallM = 0`.
- memop with misalign: no bus request. Output `dataM.valid = 1`, `misalign = 1`, `result = aluout`, `stallM = 0`.
- memop, aligned: drive `dreq.valid = 1`, `stallM = 1`, `dataM.valid = 0`.
  - If `dresp.data_ok = 0`, go to WAIT.
  - If `dresp.data_ok = 1` in the same cycle, capture `dresp.data` into `rdata_q` and go to DONE.

WAIT:
- Hold `dreq` constant (inputs are frozen by `stallM`).
- Keep `stallM = 1`.
- On `data_ok`: capture into `rdata_q`, go to DONE.

DONE:
- `dreq.valid = 0`, `stallM = 0`, `dataM.valid = 1`.
- Load: `result` = extracted `rdata_q`. Store: `result = aluout`.
- Next state is IDLE. The pipeline advances at the end of the DONE cycle.

Request formation:
- `addr = aluout`.
- `strobe = base_mask(size) << addr[2:0]`, where `base_mask` is 0x01/0x03/0x0F/0xFF. Loads use `strobe = 0`.
- `data = memwd << (8*addr[2:0])`.

Load extraction:
- `rdata_q >> (8*addr[2:0])`, truncated to the size.
- Sign- or zero-extended to 64 bit per `memext`. MSIZE8 is the raw word.

## Timing
- Non-memop and misaligned access: 0 cycles added.
- Memory access: bus latency (cycles until `data_ok`) + 1 DONE cycle.
  - `data_ok` in the request cycle gives 1 stall cycle.
- Reset values:
  - state = IDLE, `rdata_q = 0`.
  - `dreq.valid = 0`.
  - `stallM = 0`; `stallM` is 0 while reset is held regardless of `dataE`.
  - `dataM.valid` reflects `dataE` only after reset deasserts.
- Reset mid-WAIT: immediate IDLE, `dreq.valid` drops the same instant, and the in-flight response is discarded. The bus side must tolerate an abandoned request.
- `data_ok` without an outstanding request (IDLE non-memop, DONE) is ignored.
- `dreq` fields must not change while `valid` is high and `data_ok` has not been seen.
- `dataE.valid = 0` is a bubble: no request, `dataM.valid = 0`, `stallM = 0`.

## Test plan
- ALU op, `aluout = 0x1234`, `memread = memwrite = 0` -> same cycle `dataM.result = 0x1234`, `valid = 1`, `stallM = 0`, `dreq.valid = 0`.
- Byte load `addr = 0x8003`, MSIZE1, `memext = 0`, bus data 0x0000_0000_8000_0000, `data_ok` after 3 cycles ->
  - `stallM` high for 3 cycles.
  - DONE cycle `result = 0xFFFF_FFFF_FFFF_FF80`.
  - With `memext = 1`, `result = 0x80`.
- Half store `addr = 0x1006`, `memwd = 0xBEEF`, immediate `data_ok` -> `strobe = 0xC0`, `data = 0xBEEF_0000_0000_0000`, 1 stall cycle, then `dataM.valid = 1`.
- Word load `addr = 0x1002` -> `misalign = 1`, no `dreq.valid`, `stallM = 0`.
- Reset asserted in WAIT of a doubleword load -> `dreq.valid` and `stallM` drop immediately. After release, the FSM is in IDLE and a fresh request issues correctly.
- Back-to-back loads to 0x0 and 0x8 with 2-cycle latency -> two distinct requests with no overlap, each followed by exactly one DONE cycle with the correct data.
